// File: rtl/vga_pkg.sv
// vga_pkg: shared types, colour constants and RGB332 expansion for the VGA pixel path
package vga_pkg;
  localparam int COUNT_W = 10;
  typedef logic [7:0] rgb332_t;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;
  typedef enum logic {SYNC_WAIT, RUN} state_t;
  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [0:7][7:0] BAR_COLORS = {8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};
  function automatic rgb888_t rgb332_to_888(rgb332_t c);
    return '{r: {c[7:5], c[7:5], c[7:6]}, g: {c[4:2], c[4:2], c[4:3]}, b: {4{c[1:0]}}};
  endfunction
endpackage

// File: rtl/vga_pixel_pipeline_if.sv
// vga_pixel_pipeline_if: timing counts/syncs in, framebuffer read port, colour/sync out
// slave: pixel pipeline side; master: timing controller, framebuffer and display side
// TEST_PATTERN_EN adds test_mode
interface vga_pixel_pipeline_if #(parameter int ADDR_W = 16);
  import vga_pkg::*;
  logic [COUNT_W-1:0] h_count, v_count;
  logic               hsync_in, vsync_in;
  logic [ADDR_W-1:0]  mem_addr;
  logic [7:0]         mem_rdata;
  logic [7:0]         red, green, blue;
  logic               hsync, vsync, frame_start;
`ifdef TEST_PATTERN_EN
  logic               test_mode;
`endif
  modport slave (
`ifdef TEST_PATTERN_EN
    input test_mode,
`endif
    input h_count, v_count, hsync_in, vsync_in, mem_rdata,
    output mem_addr, red, green, blue, hsync, vsync, frame_start
  );
  modport master (
`ifdef TEST_PATTERN_EN
    output test_mode,
`endif
    output h_count, v_count, hsync_in, vsync_in, mem_rdata,
    input mem_addr, red, green, blue, hsync, vsync, frame_start
  );
endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line: D-deep shift register clearing to RST; ports clk, rst_n, d in, q out
module vga_delay_line #(
  parameter int W = 1,
  parameter int D = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr [D];
  always_ff @(posedge clk)
    if (!rst_n) for (int i = 0; i < D; i++) sr[i] <= RST;
    else begin
      sr[0] <= d;
      for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[D-1];
endmodule

// File: rtl/vga_pixel_pipeline.sv
// vga_pixel_pipeline: framebuffer fetch, RGB332->888 expansion and blanking with sync alignment
// ports: clk, rst_n (sync, active low), bus (vga_pixel_pipeline_if.slave)
// TEST_PATTERN_EN adds colour bars selected by test_mode
module vga_pixel_pipeline import vga_pkg::*; #(
  parameter int H_ACTIVE = 512,
  parameter int V_ACTIVE = 480,
  parameter int IMG_W_LOG2 = 8,
  parameter int IMG_H_LOG2 = 8,
  parameter int SCALE_SHIFT = 1,
  parameter int MEM_LAT = 1,
  parameter logic [7:0] BG_COLOR = 8'h00
) (
  input logic clk,
  input logic rst_n,
  vga_pixel_pipeline_if.slave bus
);
`ifdef TEST_PATTERN_EN
  localparam int SB_W = 9;
`else
  localparam int SB_W = 5;
`endif
  // syncs idle high, flags clear
  localparam logic [SB_W-1:0] SB_RST = {2'b11, (SB_W-2)'(0)};
  logic [COUNT_W-1:0] ix, iy;
  logic vis, img, first;
  logic [IMG_W_LOG2+IMG_H_LOG2-1:0] addr_q;
  logic [SB_W-1:0] sb_in, sb_a, sb_d;
  logic hs_d, vs_d, vis_d, img_d, first_d, live;
  state_t state, nxt;
  rgb332_t pix;
  rgb888_t out_q;
  logic hs_q, vs_q, fs_q;
  assign ix = bus.h_count >> SCALE_SHIFT;
  assign iy = bus.v_count >> SCALE_SHIFT;
  assign vis = bus.h_count < COUNT_W'(H_ACTIVE) && bus.v_count < COUNT_W'(V_ACTIVE);
  // out-of-image pixels must not alias onto wrapped addresses
  assign img = vis && (ix >> IMG_W_LOG2) == '0 && (iy >> IMG_H_LOG2) == '0;
  assign first = bus.h_count == '0 && bus.v_count == '0;
  assign sb_in = {bus.hsync_in, bus.vsync_in, vis, img, first
`ifdef TEST_PATTERN_EN
    , bus.test_mode, bus.h_count[8:6]
`endif
  };
  always_ff @(posedge clk)
    if (!rst_n) begin
      addr_q <= '0;
      sb_a <= SB_RST;
    end else begin
      addr_q <= {iy[IMG_H_LOG2-1:0], ix[IMG_W_LOG2-1:0]};
      sb_a <= sb_in;
    end
  vga_delay_line #(.W(SB_W), .D(MEM_LAT), .RST(SB_RST)) u_dly (
    .clk(clk), .rst_n(rst_n), .d(sb_a), .q(sb_d)
  );
  assign {hs_d, vs_d, vis_d, img_d, first_d} = sb_d[SB_W-1:SB_W-5];
  always_ff @(posedge clk) state <= !rst_n ? SYNC_WAIT : nxt;
  always_comb nxt = first_d ? RUN : state;
  // the transition cycle already shows pixel (0,0)
  assign live = vis_d && (state == RUN || first_d);
`ifdef TEST_PATTERN_EN
  logic tm_d;
  logic [2:0] bar_d;
  assign {tm_d, bar_d} = sb_d[3:0];
  always_comb pix = !live ? '0 : !img_d ? BG_COLOR : tm_d ? BAR_COLORS[bar_d] : bus.mem_rdata;
`else
  always_comb pix = !live ? '0 : !img_d ? BG_COLOR : bus.mem_rdata;
`endif
  always_ff @(posedge clk)
    if (!rst_n) begin
      out_q <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      fs_q <= 1'b0;
    end else begin
      out_q <= rgb332_to_888(pix);
      hs_q <= hs_d;
      vs_q <= vs_d;
      fs_q <= first_d;
    end
  assign bus.mem_addr = addr_q;
  assign bus.red = out_q.r;
  assign bus.green = out_q.g;
  assign bus.blue = out_q.b;
  assign bus.hsync = hs_q;
  assign bus.vsync = vs_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_vga_pixel_pipeline.sv
// tb_vga_pixel_pipeline: scoreboard bench for the default build and a 128-wide image variant
module tb_vga_pixel_pipeline;
  import vga_pkg::*;
  localparam int L = 3;
  localparam logic [7:0] TB_BARS [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};
  typedef struct {
    logic [23:0] c1;
    logic [23:0] c2;
    logic hs;
    logic vs;
    logic fs;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit tm = 1'b0;
  bit run_m = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  vga_pixel_pipeline_if #(.ADDR_W(16)) bus();
  vga_pixel_pipeline_if #(.ADDR_W(15)) bus2();
  vga_pixel_pipeline dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  vga_pixel_pipeline #(.IMG_W_LOG2(7), .BG_COLOR(8'h1C)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  assign bus2.h_count = bus.h_count;
  assign bus2.v_count = bus.v_count;
  assign bus2.hsync_in = bus.hsync_in;
  assign bus2.vsync_in = bus.vsync_in;
`ifdef TEST_PATTERN_EN
  assign bus.test_mode = tm;
  assign bus2.test_mode = tm;
`endif
  function automatic logic [7:0] mem_fn(logic [15:0] a);
    return a == 16'h0305 ? 8'hE0 : a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction
  always @(posedge clk) begin
    bus.mem_rdata <= tm ? 8'h00 : mem_fn(bus.mem_addr);
    bus2.mem_rdata <= tm ? 8'h00 : mem_fn({1'b0, bus2.mem_addr});
  end
  function automatic logic [23:0] expand(logic [7:0] c);
    int r = (int'(c[7:5]) * 255 + 3) / 7;
    int g = (int'(c[4:2]) * 255 + 3) / 7;
    int b = int'(c[1:0]) * 85;
    return {r[7:0], g[7:0], b[7:0]};
  endfunction
  function automatic logic [7:0] pix_model(int h, int v, int wlog, logic [7:0] bg, bit run, bit tmode);
    int ix = h >> 1;
    int iy = v >> 1;
    if (!(h < 512 && v < 480) || !run) return 8'h00;
    if (ix >= (1 << wlog) || iy >= 256) return bg;
    if (tmode) return TB_BARS[(h >> 6) & 7];
    return mem_fn(16'(iy * (1 << wlog) + ix));
  endfunction
  task automatic chk(input string tag, input logic [23:0] o, input logic [23:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, o, e);
    end
  endtask
  task automatic step(input int h, input int v, input bit hs = 1'b1, input bit vs = 1'b1);
    exp_t e;
    int ix = h >> 1;
    int iy = v >> 1;
    bus.h_count = 10'(h);
    bus.v_count = 10'(v);
    bus.hsync_in = hs;
    bus.vsync_in = vs;
    if (rst_n) begin
      if (h == 0 && v == 0) run_m = 1'b1;
      e.c1 = expand(pix_model(h, v, 8, 8'h00, run_m, tm));
      e.c2 = expand(pix_model(h, v, 7, 8'h1C, run_m, tm));
      e.hs = hs;
      e.vs = vs;
      e.fs = h == 0 && v == 0;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      chk("rst_rgb", {bus.red, bus.green, bus.blue}, 24'h0);
      chk("rst_hsync", bus.hsync, 1);
      chk("rst_vsync", bus.vsync, 1);
      chk("rst_fs", bus.frame_start, 0);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_state", dut.state, SYNC_WAIT);
      q.delete();
      run_m = 1'b0;
      e = '{c1: 0, c2: 0, hs: 1, vs: 1, fs: 0};
      repeat (L - 1) q.push_back(e);
    end else begin
      chk("addr", bus.mem_addr, 24'(((iy & 255) << 8) | (ix & 255)));
      chk("addr2", bus2.mem_addr, 24'(((iy & 255) << 7) | (ix & 127)));
      if (q.size() == L) begin
        e = q.pop_front();
        chk("rgb", {bus.red, bus.green, bus.blue}, e.c1);
        chk("rgb2", {bus2.red, bus2.green, bus2.blue}, e.c2);
        chk("hsync", bus.hsync, e.hs);
        chk("vsync", bus.vsync, e.vs);
        chk("frame_start", bus.frame_start, e.fs);
        chk("frame_start2", bus2.frame_start, e.fs);
      end
    end
  endtask
  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) step(95 + i, 100);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(100 + i, 100);
    step(799, 524);
    step(0, 0);
    for (int i = 1; i < 12; i++) step(i, 0);
    step(10, 6);
    step(11, 6);
    step(12, 6);
    for (int h = 505; h < 536; h++) step(h, 0, !(h >= 527 && h < 533));
    step(20, 479);
    step(20, 480, 1'b1, 1'b0);
    step(300, 10);
    step(254, 10);
    step(256, 10);
`ifdef TEST_PATTERN_EN
    tm = 1'b1;
    step(64, 0);
    step(0, 4);
    step(200, 20);
    step(300, 10);
    step(448, 30);
    tm = 1'b0;
`endif
    for (int i = 0; i < 200; i++)
      step($urandom_range(799), $urandom_range(524), 1'($urandom_range(1)), 1'($urandom_range(1)));
    rst_n = 1'b0;
    step(300, 200);
    step(301, 200);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(302 + i, 200);
    step(0, 0);
    for (int i = 0; i < 40; i++) step($urandom_range(799), $urandom_range(524));
    repeat (L) step(600, 500);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
